wb_sram_ctrl: RTL

//  Wishbone pipelined slave placed directly downstream of the cache's memory-side master (outbus).

---
 rtl/wb_sram_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_sram_ctrl.sv
// Wishbone pipelined slave to async 16-bit SRAM, big-endian, one word as up to two half accesses.
// Latency 2*WAIT+5 (full word) / WAIT+3 (one half) / 1 (sel==0); stall held high while an SRAM sequence runs.
module wb_sram_ctrl #(
  parameter int AWIDTH  = 32,
  parameter int SAWIDTH = 19,
  parameter int WAIT    = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [AWIDTH-1:0]  wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_stall_o,
  output logic [SAWIDTH-1:0] sram_adr_o,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [1:0]         sram_be_n_o
);

  typedef enum logic [2:0] {IDLE, A0, R0, A1, R1, ACK} state_t;

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t             state, state_nxt;
  logic [SAWIDTH-2:0] adr_q;
  logic               we_q;
  logic [3:0]         sel_q;
  logic [31:0]        wdat_q;
  logic [31:0]        rbuf_q;
  logic [31:0]        rdat_q;
  logic [3:0]         cnt_q;
  logic               abort_q;

  logic busy, in_a, half, accept, end_to_ack;
  logic unused_adr;

  assign unused_adr = ^{wb_adr_i[AWIDTH-1:SAWIDTH+1], wb_adr_i[1:0]};

  assign busy   = (state == A0) || (state == R0) || (state == A1) || (state == R1);
  assign in_a   = (state == A0) || (state == A1);
  assign half   = (state == A1) || (state == R1);
  assign accept = wb_cyc_i & wb_stb_i & ~busy;
  // A master that let go of cyc mid-sequence gets no ack; the FSM just goes home.
  assign end_to_ack = ~abort_q & wb_cyc_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACK: begin
        state_nxt = IDLE;
        if (accept) begin
          if (wb_sel_i[3:2] != 2'b00)      state_nxt = A0;
          else if (wb_sel_i[1:0] != 2'b00) state_nxt = A1;
          else                             state_nxt = ACK;
        end
      end
      A0: if (cnt_q == 4'd0) state_nxt = R0;
      R0: begin
        if (sel_q[1:0] != 2'b00) state_nxt = A1;
        else                     state_nxt = end_to_ack ? ACK : IDLE;
      end
      A1: if (cnt_q == 4'd0) state_nxt = R1;
      R1: state_nxt = end_to_ack ? ACK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'h0;
      wdat_q  <= 32'h0;
      rbuf_q  <= 32'h0;
      rdat_q  <= 32'h0;
      cnt_q   <= 4'h0;
      abort_q <= 1'b0;
    end else if (accept) begin
      adr_q   <= wb_adr_i[SAWIDTH:2];
      we_q    <= wb_we_i;
      sel_q   <= wb_sel_i;
      wdat_q  <= wb_dat_i;
      rbuf_q  <= 32'h0;
      cnt_q   <= WAIT_CNT;
      abort_q <= 1'b0;
      if (!wb_we_i && wb_sel_i == 4'h0) rdat_q <= 32'h0;
    end else begin
      if (busy && !wb_cyc_i) abort_q <= 1'b1;
      if (in_a) begin
        if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          cnt_q <= WAIT_CNT;
          if (!we_q) begin
            if (half) rbuf_q[15:0]  <= sram_dq_i;
            else      rbuf_q[31:16] <= sram_dq_i;
          end
        end
      end
      // Publish read data only when the ack is about to fire.
      if (busy && !we_q && state_nxt == ACK) rdat_q <= rbuf_q;
    end
  end

  assign wb_stall_o   = busy;
  assign wb_ack_o     = (state == ACK) & wb_cyc_i;
  assign wb_dat_o     = rdat_q;
  assign sram_adr_o   = {adr_q, half};
  assign sram_dq_o    = half ? wdat_q[15:0] : wdat_q[31:16];
  assign sram_dq_oe_o = busy & we_q;
  assign sram_ce_n_o  = ~busy;
  assign sram_oe_n_o  = ~(in_a & ~we_q);
  assign sram_we_n_o  = ~(in_a & we_q);
  assign sram_be_n_o  = busy ? ~(half ? sel_q[1:0] : sel_q[3:2]) : 2'b11;

endmodule
